i2s_audio_in: RTL and testbench

- I2S receiver (slave) for the on-board codec ADC path and external I2S sources; the receive-side counterpart of i2s_audio_out.
- bclk and lrclk come from the FPGA-side clock generator or an external master. They are treated as asynchronous and oversampled in the clk domain.
- Deserialises MSB-first two's-complement left/right words and presents a stereo pair with a one-cycle valid strobe to lab_top (feeds the mic/sound-style sample ports).

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_audio_in_sync_edge.sv | 29 ++
 rtl/i2s_audio_in.sv | 146 ++++++++++++++
 tb/tb_i2s_audio_in.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S receive path.
package i2s_pkg;

   localparam logic [0:0] S_SYNC = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   typedef enum logic [0:0] {
      SYNC = S_SYNC,
      RUN  = S_RUN
   } state_t;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   // clk must run at least this many times faster than bclk
   localparam int MIN_CLK_BCLK_RATIO = 4;

endpackage

// File: rtl/i2s_audio_in_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with a registered
// previous value so a clean single-cycle rise pulse can be derived.
module i2s_sync_edge #(
   parameter int w_sync = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise
);

   logic [w_sync-1:0] chain;
   logic              prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[w_sync-2:0], din};
         prev  <= chain[w_sync-1];
      end
   end

   assign level = chain[w_sync-1];
   assign rise  = level & ~prev;

endmodule

// File: rtl/i2s_audio_in.sv
// I2S slave receiver: oversamples bclk/lrclk/sdata in the clk domain and
// deserialises MSB-first left/right words into a stereo pair with a valid strobe.
//
// state | meaning
// SYNC  | waiting for an observed lrclk change to align to a word boundary
// RUN   | shifting in bits; each lrclk change commits the ending word
module i2s_audio_in
   import i2s_pkg::*;
#(
   parameter int w_sample = 16,
   parameter int w_sync   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bclk,
   input  logic                lrclk,
   input  logic                sdata,
   output logic [w_sample-1:0] left,
   output logic [w_sample-1:0] right,
   output logic                valid,
   output logic                short_frame
);

   localparam int                w_cnt    = $clog2(w_sample + 1);
   localparam logic [w_cnt-1:0]  cnt_full = w_cnt'(w_sample);

   logic bclk_rise, bclk_level_unused;
   logic lr_level, lr_rise_unused;
   logic sd_level, sd_rise_unused;

   i2s_sync_edge #(.w_sync(w_sync)) u_sync_bclk (
      .clk   (clk),
      .rst   (rst),
      .din   (bclk),
      .level (bclk_level_unused),
      .rise  (bclk_rise)
   );

   i2s_sync_edge #(.w_sync(w_sync)) u_sync_lrclk (
      .clk   (clk),
      .rst   (rst),
      .din   (lrclk),
      .level (lr_level),
      .rise  (lr_rise_unused)
   );

   i2s_sync_edge #(.w_sync(w_sync)) u_sync_sdata (
      .clk   (clk),
      .rst   (rst),
      .din   (sdata),
      .level (sd_level),
      .rise  (sd_rise_unused)
   );

   // One sample stage between edge detect and the FSM keeps lr/d aligned
   // with the strobe and fixes the port-to-output latency at w_sync + 2.
   logic stb, lr_s, d_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         stb  <= 1'b0;
         lr_s <= 1'b0;
         d_s  <= 1'b0;
      end else begin
         stb  <= bclk_rise;
         lr_s <= lr_level;
         d_s  <= sd_level;
      end
   end

   logic [0:0]          state;
   logic                primed;
   logic                lr_prev;
   logic                left_seen;
   logic [w_cnt-1:0]    cnt;
   logic [w_cnt-1:0]    n;
   logic [w_sample-1:0] shreg;
   logic [w_sample-1:0] shreg_next;
   logic [w_sample-1:0] word;
   logic                room;
   logic                lr_change;

   assign room       = (cnt < cnt_full);
   assign lr_change  = (lr_s != lr_prev);
   assign shreg_next = room ? {shreg[w_sample-2:0], d_s} : shreg;
   assign n          = room ? cnt + 1'b1 : cnt;
   assign word       = shreg_next << (cnt_full - n);

   // The first rise after reset only captures lrclk, so a word already in
   // flight at reset is never mistaken for a boundary and gets discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_SYNC;
         primed      <= 1'b0;
         lr_prev     <= 1'b0;
         left_seen   <= 1'b0;
         cnt         <= '0;
         shreg       <= '0;
         left        <= '0;
         right       <= '0;
         valid       <= 1'b0;
         short_frame <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (stb) begin
            primed  <= 1'b1;
            lr_prev <= lr_s;
            if (primed) begin
               case (state)
                  S_SYNC: begin
                     if (lr_change) begin
                        shreg <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                     end
                  end
                  S_RUN: begin
                     if (!lr_change) begin
                        if (room) begin
                           shreg <= shreg_next;
                           cnt   <= n;
                        end
                     end else begin
                        if (n != cnt_full) short_frame <= 1'b1;
                        if (lr_prev == CH_LEFT) begin
                           left      <= word;
                           left_seen <= 1'b1;
                        end else begin
                           right <= word;
                           if (left_seen) begin
                              valid     <= 1'b1;
                              left_seen <= 1'b0;
                           end
                        end
                        shreg <= '0;
                        cnt   <= '0;
                     end
                  end
                  default: state <= S_SYNC;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_audio_in.sv
// Self-checking bench for i2s_audio_in: drives an I2S bit stream and compares
// against a word-level model of the received stereo pairs.
module tb_i2s_audio_in;

   localparam int W_SAMPLE = 16;
   localparam int W_SYNC   = 2;
   localparam int LAT      = W_SYNC + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bclk = 1'b0;
   logic        lrclk = 1'b0;
   logic        sdata = 1'b0;
   logic [15:0] left, right;
   logic        valid, short_frame;

   i2s_audio_in #(.w_sample(W_SAMPLE), .w_sync(W_SYNC)) dut (
      .clk         (clk),
      .rst         (rst),
      .bclk        (bclk),
      .lrclk       (lrclk),
      .sdata       (sdata),
      .left        (left),
      .right       (right),
      .valid       (valid),
      .short_frame (short_frame)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      bit          ch;
      logic [15:0] word;
      bit          short_set;
      bit          pulse;
   } ev_t;

   ev_t         pend[$];
   bit          m_bits[$];
   bit          m_primed = 0, m_run = 0, m_lr_prev = 0, m_left_seen = 0;
   int          m_valid_cnt = 0, dut_valid_cnt = 0;
   int          last_pulse_rise = -1, last_valid_seen = -1;
   logic [15:0] exp_left = '0, exp_right = '0;
   bit          exp_short = 0, exp_valid = 0;
   int          rst_due = -1;
   bit          chk_en = 0;
   bit          tx_pending = 0;
   int          checks = 0, errors = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Word-level model: collect the bits of the current channel slot (the
   // delay-slot bit included) and commit the first W_SAMPLE of them when lrclk flips.
   task automatic model_rise(bit lr, bit d);
      ev_t e;
      if (!m_primed) begin
         m_primed  = 1;
         m_lr_prev = lr;
         return;
      end
      if (!m_run) begin
         if (lr != m_lr_prev) begin
            m_run = 1;
            m_bits.delete();
         end
      end else begin
         m_bits.push_back(d);
         if (lr != m_lr_prev) begin
            e.due  = cyc + LAT;
            e.ch   = m_lr_prev;
            e.word = '0;
            for (int i = 0; i < W_SAMPLE; i++)
               if (i < m_bits.size()) e.word[W_SAMPLE-1-i] = m_bits[i];
            e.short_set = (m_bits.size() < W_SAMPLE);
            e.pulse = 0;
            if (!m_lr_prev) m_left_seen = 1;
            else if (m_left_seen) begin
               e.pulse = 1;
               m_left_seen = 0;
               m_valid_cnt++;
               last_pulse_rise = cyc;
            end
            pend.push_back(e);
            m_bits.delete();
         end
      end
      m_lr_prev = lr;
   endtask

   task automatic model_reset();
      m_primed = 0;
      m_run = 0;
      m_lr_prev = 0;
      m_left_seen = 0;
      m_bits.delete();
      pend.delete();
      rst_due = cyc + 1;
   endtask

   always @(posedge clk) begin : compare
      ev_t e;
      #1;
      if (cyc == rst_due) begin
         exp_left  = '0;
         exp_right = '0;
         exp_short = 0;
      end
      exp_valid = 0;
      while (pend.size() > 0 && pend[0].due <= cyc) begin
         e = pend.pop_front();
         if (e.ch) exp_right = e.word;
         else      exp_left  = e.word;
         if (e.short_set) exp_short = 1;
         if (e.pulse) exp_valid = 1;
      end
      if (valid === 1'b1) begin
         dut_valid_cnt++;
         last_valid_seen = cyc;
      end
      if (chk_en) begin
         check("left", left, exp_left);
         check("right", right, exp_right);
         check("valid", valid, exp_valid);
         check("short_frame", short_frame, exp_short);
      end
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic ticks(int n);
      repeat (n) tick();
   endtask

   // One bclk period: falling edge with new lrclk/sdata, then the rising edge.
   task automatic bclk_bit(bit lr, bit d);
      bclk  = 1'b0;
      lrclk = lr;
      sdata = d;
      ticks(4);
      bclk = 1'b1;
      model_rise(lr, d);
      ticks(4);
   endtask

   // A slot of len bclks for channel ch; its first rise carries the previous word's LSB.
   task automatic send_word(bit ch, logic [63:0] value, int len);
      for (int k = 0; k < len; k++)
         bclk_bit(ch, (k == 0) ? tx_pending : value[len - k]);
      tx_pending = value[0];
   endtask

   task automatic reset_mid();
      bclk = 1'b0;
      tick();
      rst = 1'b1;
      model_reset();
      tick();
      rst = 1'b0;
      check("rst_left", left, 0);
      check("rst_right", right, 0);
      check("rst_valid", valid, 0);
      check("rst_short", short_frame, 0);
      ticks(2);
   endtask

   function automatic int pick_len();
      int sel;
      sel = $urandom_range(0, 4);
      case (sel)
         0: return 12;
         1: return 16;
         2: return 24;
         3: return 32;
         default: return $urandom_range(1, 40);
      endcase
   endfunction

   initial begin : stimulus
      logic [63:0] v, lx, rx;
      int          vcnt0;

      rst = 1'b1;
      ticks(5);
      model_reset();
      ticks(1);
      rst = 1'b0;
      ticks(2);
      chk_en = 1;
      check("reset_left", left, 0);
      check("reset_right", right, 0);
      check("reset_valid", valid, 0);
      check("reset_short", short_frame, 0);

      // start in the middle of a right word; it must be discarded
      v = {$urandom, $urandom};
      send_word(1, v, 7);
      send_word(0, 64'h8001, 16);
      send_word(1, 64'h7FFE, 16);
      send_word(0, 64'h1234_ABCD, 32);
      check("t1_left", left, 16'h8001);
      check("t1_right", right, 16'h7FFE);
      check("t1_short", short_frame, 0);
      check("t1_model_left", exp_left, 16'h8001);
      check("t1_one_valid", dut_valid_cnt, 1);
      check("t1_latency", last_valid_seen - last_pulse_rise, LAT);

      send_word(1, 64'hFEDC_0001, 32);
      send_word(0, 64'hABC, 12);
      check("t2_left", left, 16'h1234);
      check("t2_right", right, 16'hFEDC);
      check("t2_short", short_frame, 0);
      check("t2_model_right", exp_right, 16'hFEDC);

      send_word(1, 64'h123, 12);
      v = {$urandom, $urandom};
      send_word(0, v, 16);
      check("t3_left", left, 16'hABC0);
      check("t3_right", right, 16'h1230);
      check("t3_short", short_frame, 1);
      check("t3_model_left", exp_left, 16'hABC0);

      // reset in the middle of a left word
      v = {$urandom, $urandom};
      send_word(1, v, 16);
      v = {$urandom, $urandom};
      send_word(0, v, 9);
      reset_mid();
      vcnt0 = dut_valid_cnt;
      v = {$urandom, $urandom};
      send_word(0, v, 7);
      v = {$urandom, $urandom};
      send_word(1, v, 16);
      lx = {48'h0, 16'($urandom)};
      rx = {48'h0, 16'($urandom)};
      send_word(0, lx, 16);
      send_word(1, rx, 16);
      v = {$urandom, $urandom};
      send_word(0, v, 16);
      check("rst_frame_left", left, lx[15:0]);
      check("rst_frame_right", right, rx[15:0]);
      check("rst_frame_short", short_frame, 0);
      check("rst_frame_valids", dut_valid_cnt - vcnt0, 1);

      // randomized frames with mixed word lengths
      v = {$urandom, $urandom};
      send_word(1, v, 16);
      for (int f = 0; f < 25; f++) begin
         v = {$urandom, $urandom};
         send_word(0, v, pick_len());
         v = {$urandom, $urandom};
         send_word(1, v, pick_len());
      end
      send_word(0, 64'h0, 2);
      ticks(10);
      check("total_valids", dut_valid_cnt, m_valid_cnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
